siso_sequencer: RTL and testbench
=================================

# siso_sequencer

Phase sequencer for the HDSISO8 shift-register core. It owns the 4-bit Johnson counter and the 8 one-hot phase strobes that clock data through the SISO, one full revolution per shifted bit. It also gates the LFSR8 pattern generator so that it advances once per shifted bit. It sits between the top-level clock/reset soup (`CLK_OUT`, `INT_RESET`) and the SISO/LFSR datapath, and replaces the constant `Johnson`/`PULSES` placeholders.

## Interface
- `LEN_W`, default 8: width of the burst-length counter.

- `CLK` in 1: single clock (the selected `CLK_OUT`).
- `RESET` in 1: asynchronous, active-low reset.
- `RUN` in 1: level; free-run while high.
- `STEP` in 1: single-phase advance, acted on at its rising edge.
- `BURST_GO` in 1: start-of-burst strobe.
- `BURST_LEN` in `LEN_W`: number of revolutions (bits) per burst.
- `LFSR_EN` in 1: request pattern advance.
- `JOHNSON` out 4: current Johnson state.
- `PULSES` out 8: one-hot phase strobe.
- `SHIFT_TICK` out 1: revolution complete (one bit shifted).
- `LFSR_TICK` out 1: `SHIFT_TICK & LFSR_EN`; drives the LFSR8 enable.
- `BUSY` out 1: sequencer is not IDLE.
- `DONE` out 1: one-cycle burst-complete strobe.
- `ERR` out 1: sticky illegal-state flag.

## Operation
- **Johnson order, index 0..7:** 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. The advance function is `{J[2:0], ~J[3]}`.
- **Advance cycle.** `JOHNSON` takes the next state. In the same cycle, `PULSES` is set to `onehot(index(next))`.
- **Non-advance cycle.** `PULSES` = 0. There are no idle strobes.
- **Wrap.** `SHIFT_TICK` is asserted exactly in the cycle where `PULSES[0]` is asserted, i.e. on entry into 0000.
- **FSM states:** IDLE, FREE, DRAIN, BURST.
  - IDLE → BURST when `BURST_GO` is high and `BURST_LEN` ≠ 0. The counter is loaded with `BURST_LEN`.
  - IDLE, `BURST_GO` with `BURST_LEN` = 0: `DONE` pulses on the next cycle and the FSM stays in IDLE.
  - IDLE → FREE when `RUN` is high. `BURST_GO` has priority over `RUN`.
  - IDLE with a `STEP` rising edge (previous `STEP` registered): exactly one advance, FSM stays in IDLE. A held `STEP` gives one advance only. Stepping may leave `JOHNSON` mid-revolution.
  - FREE: advance every cycle. When `RUN` falls, go to DRAIN if `JOHNSON` ≠ 0000, otherwise to IDLE.
  - DRAIN: advance every cycle until 0000 is entered, then go to IDLE. The SISO is never left mid-shift by `RUN`.
  - BURST: advance every cycle. Decrement the burst counter on each `SHIFT_TICK`. On the tick that brings it to 0, pulse `DONE` (coincident with that `SHIFT_TICK`) and go to IDLE.
  - BURST starting mid-revolution (after stepping): the partial revolution counts as the first bit.
- **Ignored inputs.** `BURST_GO` outside IDLE is ignored, with no queuing. `RUN` and `STEP` are ignored in BURST and DRAIN. `STEP` is ignored in FREE.
- **Illegal state** (any of the 8 non-Johnson codes):
  - The next state is forced to 0000.
  - `PULSES` = 0 and `SHIFT_TICK` = 0 in that recovery cycle.
  - `ERR` is set and stays high until `RESET`.
  - The FSM goes to IDLE; any burst is aborted without `DONE`.

## Timing
- **Reset values** (asynchronous, immediate, including mid-burst): `JOHNSON` = 0000, `PULSES` = 0, `SHIFT_TICK` = 0, `LFSR_TICK` = 0, `BUSY` = 0, `DONE` = 0, `ERR` = 0, FSM = IDLE, burst counter = 0.
- **All outputs are registered.** There is no combinational path from inputs to outputs.
- **`RUN` start latency.** `RUN` sampled high at edge k (from IDLE) gives the first advance at edge k+1, with `BUSY` high from k+1.
- **`BURST_GO` latency** is identical to `RUN`. A burst of N revolutions from 0000 occupies 8·N advance cycles.
- **`BUSY` fall.** `BUSY` drops on the edge after the final 0000 entry.
- **`STEP` latency.** A `STEP` rising edge sampled at edge k gives its advance at edge k+1.

## Structure
- **Package `hdsiso8_pkg`:**
  - 4-bit Johnson state constants `J_S0`..`J_S7`.
  - `johnson_next` function.
  - `johnson_index` function (returns the index plus a legal flag).
  - FSM state encoding.
- **Sub-module `johnson4`:** counter register, advance/clear inputs, legality check, one-hot decode.
- **`siso_sequencer`:** FSM, `STEP` edge detector, burst counter, output registers.

## Test plan
- **Reset mid-run.** Assert `RUN` for 5 cycles, then pull `RESET` low → all outputs 0 immediately, before the next edge.
- **Free run.** `RUN` high for 16 cycles from 0000:
  - `PULSES` = 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, 0x01 and repeat.
  - `SHIFT_TICK` on advances 8 and 16.
  - With `LFSR_EN` = 1, `LFSR_TICK` is asserted on the same two cycles.
- **Drain.** Drop `RUN` at state 0111 → exactly 5 further advances ending in 0000 with `SHIFT_TICK`; `BUSY` low one cycle later.
- **Burst.** `BURST_LEN` = 3 with a `BURST_GO` strobe:
  - 24 advances, `BUSY` high for 24 cycles.
  - `DONE` coincident with the 3rd `SHIFT_TICK`.
  - A second `BURST_GO` at advance 10 is ignored.
  - Repeat with `BURST_LEN` = 0 → `DONE` on the next cycle, no advance.
- **Step.** Hold `STEP` high for 5 cycles from IDLE → exactly one advance (0000 → 0001, `PULSES` = 0x02), then `PULSES` = 0.
- **Illegal state.** Force `JOHNSON` = 0101 during BURST → next cycle `JOHNSON` = 0000, `PULSES` = 0, `ERR` = 1, FSM IDLE, no `DONE`. `ERR` stays 1 through later `RUN` activity until `RESET`.

Source files
------------

// File: rtl/hdsiso8_pkg.sv
// Shared definitions for the HDSISO8 phase sequencer: Johnson state codes,
// the advance and index helpers, and the sequencer FSM encoding.
package hdsiso8_pkg;

    localparam logic [3:0] J_S0 = 4'b0000;
    localparam logic [3:0] J_S1 = 4'b0001;
    localparam logic [3:0] J_S2 = 4'b0011;
    localparam logic [3:0] J_S3 = 4'b0111;
    localparam logic [3:0] J_S4 = 4'b1111;
    localparam logic [3:0] J_S5 = 4'b1110;
    localparam logic [3:0] J_S6 = 4'b1100;
    localparam logic [3:0] J_S7 = 4'b1000;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } j_index_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FREE  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_BURST = 2'd3
    } seq_state_t;

    function automatic logic [3:0] johnson_next(input logic [3:0] j);
        return {j[2:0], ~j[3]};
    endfunction

    // Position of a code within the revolution; legal is low for the
    // eight codes a 4-bit Johnson ring never visits.
    function automatic j_index_t johnson_index(input logic [3:0] j);
        j_index_t r;
        r.legal = 1'b1;
        r.idx   = 3'd0;
        case (j)
            J_S0:    r.idx = 3'd0;
            J_S1:    r.idx = 3'd1;
            J_S2:    r.idx = 3'd2;
            J_S3:    r.idx = 3'd3;
            J_S4:    r.idx = 3'd4;
            J_S5:    r.idx = 3'd5;
            J_S6:    r.idx = 3'd6;
            J_S7:    r.idx = 3'd7;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/johnson4.sv
// 4-bit Johnson ring with advance/clear, legality check and the one-hot
// strobe pattern of the state it would advance into.
module johnson4
    import hdsiso8_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_adv,
    input  logic       i_clr,
    output logic [3:0] o_state,
    output logic [3:0] o_next,
    output logic       o_legal,
    output logic [7:0] o_next_onehot
);

    logic [3:0] r_state;
    j_index_t   w_cur;
    logic [2:0] w_next_idx;

    assign w_cur      = johnson_index(r_state);
    assign w_next_idx = w_cur.idx + 3'd1;

    assign o_state       = r_state;
    assign o_next        = johnson_next(r_state);
    assign o_legal       = w_cur.legal;
    assign o_next_onehot = w_cur.legal ? (8'd1 << w_next_idx) : 8'd0;

    // Ring register; clear wins so an illegal code always recovers to 0000.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= J_S0;
        end else if (i_clr) begin
            r_state <= J_S0;
        end else if (i_adv) begin
            r_state <= johnson_next(r_state);
        end
    end

endmodule

// File: rtl/siso_sequencer.sv
// Phase sequencer for the HDSISO8 SISO: drives the Johnson ring, the
// one-hot phase strobes, the per-bit shift tick and the LFSR8 enable.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | parked; accepts BURST_GO, RUN or a single STEP
// ST_FREE  | advancing every cycle while RUN is high
// ST_DRAIN | RUN dropped mid-revolution; advancing until 0000 is entered
// ST_BURST | advancing for BURST_LEN revolutions, then DONE
module siso_sequencer
    import hdsiso8_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             BURST_GO,
    input  logic [LEN_W-1:0] BURST_LEN,
    input  logic             LFSR_EN,
    output logic [3:0]       JOHNSON,
    output logic [7:0]       PULSES,
    output logic             SHIFT_TICK,
    output logic             LFSR_TICK,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    logic [3:0]       w_j;
    logic [3:0]       w_j_next;
    logic             w_legal;
    logic [7:0]       w_nxt_onehot;
    logic             w_adv;
    logic             w_clr;
    logic             w_wrap;
    logic             w_step_rise;
    logic             w_done;
    seq_state_t       w_fsm_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;

    seq_state_t       r_fsm;
    logic [LEN_W-1:0] r_cnt;
    logic             r_step_d;
    logic [7:0]       r_pulses;
    logic             r_tick;
    logic             r_lfsr_tick;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    johnson4 u_jc (
        .i_clk        (CLK),
        .i_rst_n      (RESET),
        .i_adv        (w_adv),
        .i_clr        (w_clr),
        .o_state      (w_j),
        .o_next       (w_j_next),
        .o_legal      (w_legal),
        .o_next_onehot(w_nxt_onehot)
    );

    assign w_wrap      = (w_j_next == J_S0);
    assign w_step_rise = STEP & ~r_step_d;

    // Next-state, advance and burst-count decisions; an illegal ring code
    // overrides everything and drops the sequencer back to IDLE.
    always_comb begin
        w_adv     = 1'b0;
        w_clr     = 1'b0;
        w_done    = 1'b0;
        w_fsm_nxt = r_fsm;
        w_cnt_nxt = r_cnt;
        if (!w_legal) begin
            w_clr     = 1'b1;
            w_fsm_nxt = ST_IDLE;
            w_cnt_nxt = '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (BURST_GO) begin
                        if (BURST_LEN != '0) begin
                            w_fsm_nxt = ST_BURST;
                            w_cnt_nxt = BURST_LEN;
                        end else begin
                            w_done = 1'b1;
                        end
                    end else if (RUN) begin
                        w_fsm_nxt = ST_FREE;
                    end else if (w_step_rise) begin
                        w_adv = 1'b1;
                    end
                end
                ST_FREE: begin
                    if (RUN) begin
                        w_adv = 1'b1;
                    end else if (w_j == J_S0) begin
                        w_fsm_nxt = ST_IDLE;
                    end else begin
                        w_adv     = 1'b1;
                        w_fsm_nxt = w_wrap ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    w_adv = 1'b1;
                    if (w_wrap) begin
                        w_fsm_nxt = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    w_adv = 1'b1;
                    if (w_wrap) begin
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            w_done    = 1'b1;
                            w_fsm_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_fsm_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM, burst counter, STEP history and all registered outputs. BUSY
    // trails the state by one edge so it covers the final 0000 entry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fsm       <= ST_IDLE;
            r_cnt       <= '0;
            r_step_d    <= 1'b0;
            r_pulses    <= 8'd0;
            r_tick      <= 1'b0;
            r_lfsr_tick <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step_d    <= STEP;
            r_pulses    <= w_adv ? w_nxt_onehot : 8'd0;
            r_tick      <= w_adv & w_wrap;
            r_lfsr_tick <= w_adv & w_wrap & LFSR_EN;
            r_busy      <= (r_fsm != ST_IDLE);
            r_done      <= w_done;
            r_err       <= r_err | ~w_legal;
        end
    end

    assign JOHNSON    = w_j;
    assign PULSES     = r_pulses;
    assign SHIFT_TICK = r_tick;
    assign LFSR_TICK  = r_lfsr_tick;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;

endmodule

// File: tb/tb_siso_sequencer.sv
// Self-checking bench for siso_sequencer: directed scenarios followed by a
// random phase, all compared each cycle against a revolution-position model.
module tb_siso_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       burst_go;
    logic [7:0] burst_len;
    logic       lfsr_en;
    logic [3:0] johnson;
    logic [7:0] pulses;
    logic       shift_tick;
    logic       lfsr_tick;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    // reference model: position within the revolution (-1 = corrupted ring)
    int   m_pos;
    bit   m_free, m_drain, m_burst, m_sprev, m_err;
    int   m_left;
    logic [3:0] e_j;
    logic [7:0] e_p;
    logic e_tick, e_lt, e_busy, e_done, e_err;

    siso_sequencer #(.LEN_W(8)) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .RUN       (run),
        .STEP      (step),
        .BURST_GO  (burst_go),
        .BURST_LEN (burst_len),
        .LFSR_EN   (lfsr_en),
        .JOHNSON   (johnson),
        .PULSES    (pulses),
        .SHIFT_TICK(shift_tick),
        .LFSR_TICK (lfsr_tick),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [3:0] jcode(input int i);
        if (i <= 4) return 4'((1 << i) - 1);
        return 4'((15 << (i - 4)) & 15);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_free = 0; m_drain = 0; m_burst = 0; m_sprev = 0; m_err = 0; m_left = 0;
        e_j = 4'd0; e_p = 8'd0; e_tick = 0; e_lt = 0; e_busy = 0; e_done = 0; e_err = 0;
    endtask

    // One clock of the spec's rules, using the inputs as they stand at the edge.
    task automatic model_step();
        bit adv, dn, active;
        adv = 0; dn = 0;
        active = m_free | m_drain | m_burst;
        if (m_pos < 0) begin
            m_pos = 0; m_free = 0; m_drain = 0; m_burst = 0; m_left = 0; m_err = 1;
        end else if (m_burst || m_drain) begin
            adv = 1;
        end else if (m_free) begin
            if (run) adv = 1;
            else begin
                m_free = 0;
                if (m_pos != 0) begin m_drain = 1; adv = 1; end
            end
        end else if (burst_go) begin
            if (burst_len != 0) begin m_burst = 1; m_left = int'(burst_len); end
            else dn = 1;
        end else if (run) begin
            m_free = 1;
        end else if (step && !m_sprev) begin
            adv = 1;
        end
        if (adv) begin
            m_pos = (m_pos + 1) % 8;
            if (m_pos == 0) begin
                m_drain = 0;
                if (m_burst) begin
                    m_left--;
                    if (m_left == 0) begin m_burst = 0; dn = 1; end
                end
            end
        end
        m_sprev = step;
        e_j    = jcode(m_pos);
        e_p    = adv ? (8'd1 << m_pos) : 8'd0;
        e_tick = adv && (m_pos == 0);
        e_lt   = e_tick && lfsr_en;
        e_busy = active;
        e_done = dn;
        e_err  = m_err;
    endtask

    task automatic check_all();
        chk("johnson", {4'd0, johnson}, {4'd0, e_j});
        chk("pulses", pulses, e_p);
        chk("shift_tick", {7'd0, shift_tick}, {7'd0, e_tick});
        chk("lfsr_tick", {7'd0, lfsr_tick}, {7'd0, e_lt});
        chk("busy", {7'd0, busy}, {7'd0, e_busy});
        chk("done", {7'd0, done}, {7'd0, e_done});
        chk("err", {7'd0, err}, {7'd0, e_err});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_johnson"}, {4'd0, johnson}, 8'd0);
        chk({tag, "_pulses"}, pulses, 8'd0);
        chk({tag, "_outs"}, {3'd0, shift_tick, lfsr_tick, busy, done, err}, 8'd0);
        model_reset();
        run = 0; step = 0; burst_go = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int advs, ticks, lticks, busy_n, done_n, t1, t2;
        bit found;
        rst_n = 1'b0; run = 0; step = 0; burst_go = 0; burst_len = 8'd0; lfsr_en = 0;
        model_reset();
        do_reset("por");

        // reset in the middle of a free run
        run = 1;
        for (int i = 0; i < 5; i++) cyc();
        do_reset("midrun");

        // free run, 16 advances
        lfsr_en = 1; run = 1;
        cyc();
        advs = 0; ticks = 0; lticks = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (pulses != 0) advs++;
            if (shift_tick) begin
                ticks++;
                if (ticks == 1) t1 = advs; else t2 = advs;
            end
            if (lfsr_tick) lticks++;
        end
        chk("free_advances", 8'(advs), 8'd16);
        chk("free_tick1_at", 8'(t1), 8'd8);
        chk("free_tick2_at", 8'(t2), 8'd16);
        chk("free_lfsr_ticks", 8'(lticks), 8'd2);
        run = 0; lfsr_en = 0;
        cyc(); cyc();

        // drain from 0111
        run = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (johnson == 4'b0111) found = 1;
        end
        chk("drain_reach_0111", {7'd0, found}, 8'd1);
        run = 0; advs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (pulses != 0) advs++;
            if (!busy) break;
        end
        chk("drain_advances", 8'(advs), 8'd5);
        chk("drain_busy_low", {7'd0, busy}, 8'd0);

        // burst of 3 with a stray BURST_GO mid-burst
        burst_len = 8'd3; burst_go = 1;
        cyc();
        burst_go = 0;
        advs = 0; busy_n = busy ? 1 : 0; done_n = 0; ticks = 0;
        for (int i = 0; i < 40; i++) begin
            burst_go = (advs == 10);
            cyc();
            if (pulses != 0) advs++;
            if (shift_tick) ticks++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                chk("burst_done_on_tick3", {6'd0, shift_tick, (ticks == 3)}, 8'd3);
            end
        end
        burst_go = 0;
        chk("burst_advances", 8'(advs), 8'd24);
        chk("burst_busy_cycles", 8'(busy_n), 8'd24);
        chk("burst_done_count", 8'(done_n), 8'd1);

        // zero-length burst
        burst_len = 8'd0; burst_go = 1;
        cyc();
        burst_go = 0;
        chk("burst0_done", {7'd0, done}, 8'd1);
        chk("burst0_no_adv", pulses, 8'd0);
        cyc();

        // held STEP gives a single advance
        step = 1; advs = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                chk("step_johnson", {4'd0, johnson}, 8'h01);
                chk("step_pulses", pulses, 8'h02);
            end
            if (pulses != 0) advs++;
        end
        step = 0;
        chk("step_advances", 8'(advs), 8'd1);
        cyc();

        // corrupted ring during a burst
        burst_len = 8'd2; burst_go = 1;
        cyc();
        burst_go = 0;
        for (int i = 0; i < 3; i++) cyc();
        force dut.u_jc.r_state = 4'b0101;
        #1;
        release dut.u_jc.r_state;
        m_pos = -1;
        cyc();
        chk("illegal_johnson", {4'd0, johnson}, 8'd0);
        chk("illegal_pulses", pulses, 8'd0);
        chk("illegal_err", {7'd0, err}, 8'd1);
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done) done_n++;
        end
        chk("illegal_no_done", 8'(done_n), 8'd0);
        run = 1;
        for (int i = 0; i < 10; i++) cyc();
        run = 0;
        for (int i = 0; i < 12; i++) cyc();
        chk("err_sticky", {7'd0, err}, 8'd1);
        do_reset("err_clear");

        // random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 10) run = ~run;
            step      = ($urandom_range(0, 3) == 0);
            burst_go  = ($urandom_range(0, 19) == 0);
            burst_len = 8'($urandom_range(0, 3));
            lfsr_en   = ($urandom_range(0, 1) == 1);
            cyc();
            if (i == 250) do_reset("rand_reset");
        end
        run = 0; step = 0; burst_go = 0;
        for (int i = 0; i < 40; i++) cyc();
        do_reset("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
